instruction_fetch: RTL and testbench

- Fetch stage of the no-pipeline core. Keeps the fetch PC, issues word requests to instruction memory, and buffers in-order responses in a small FIFO.
- Presents {instruction, PC} pairs to instruction_decoding over a valid/ready handshake.
- Accepts branch/jump redirects from EX. On a redirect it flushes buffered entries and discards responses that are still in flight.

---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/instruction_fetch_if.sv | 50 +++++
 rtl/instruction_fetch_fifo.sv | 77 +++++++
 rtl/instruction_fetch.sv | 133 +++++++++++++
 tb/tb_instruction_fetch.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// ----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared constants for the fetch stage and its instruction buffer.
//   RESET_INSTR   : instruction word presented while no entry is buffered
//   PC_STEP       : byte distance between consecutive instruction words
//   PC_ALIGN_MASK : low address bits forced to zero on a redirect target
// ----------------------------------------------------------------------------
package instruction_fetch_pkg;

    localparam logic [31:0] RESET_INSTR   = 32'h0000_0000;
    localparam int unsigned PC_STEP       = 4;
    localparam int unsigned PC_ALIGN_MASK = 3;

endpackage

// File: rtl/instruction_fetch_if.sv
// ----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the instruction-memory request/response bus and the decode-side
// valid/ready handshake of the fetch stage.
//   master : the fetch stage (drives requests and the decode head)
//   slave  : the environment (memory plus decode)
// Signals:
//   imem_req_valid/imem_req_ready/imem_req_addr : word request to memory
//   imem_resp_valid/imem_resp_data              : in-order, non-stallable response
//   out_valid/out_ready/instruction/out_pc_value : {instruction, PC} to decode
// ----------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int unsigned XLEN = 32
);

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] out_pc_value;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        output out_valid,
        input  out_ready,
        output instruction,
        output out_pc_value
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        input  out_valid,
        output out_ready,
        input  instruction,
        input  out_pc_value
    );

endinterface

// File: rtl/instruction_fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding fetched {instruction, PC} entries.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push, push_data : write an entry (ignored when full without a pop)
//   pop          : remove the head entry (ignored when empty)
//   flush        : discard every entry; wins over push and pop
//   head_data    : current head entry (raw storage, qualify with empty)
//   count, empty : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign count     = count_q;
    assign head_data = storage[rd_ptr];

    // A push into a full buffer is only accepted when the head leaves in the
    // same cycle, which keeps the slot it reuses valid.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Entry storage needs no reset; the occupancy count qualifies every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: keeps the fetch PC, issues word requests to instruction memory
// under a credit limit, buffers in-order responses and hands {instruction, PC}
// pairs to decode. A redirect flushes the buffer and marks every request still
// in flight to be discarded when its response returns.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   redirect_valid  : one-cycle pulse restarting fetch at redirect_pc
//   redirect_pc     : redirect target, low two bits ignored
//   bus (master)    : memory request/response and decode handshake
// ----------------------------------------------------------------------------
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 2,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    instruction_fetch_if.master bus
);

    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned FC_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = 32 + XLEN;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    tag_pc;
    logic [XLEN-1:0]    redirect_target;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   inflight_next;
    logic [CNT_W-1:0]   drop;
    logic [CNT_W-1:0]   drop_next;
    logic               fetch_en;
    logic [FC_W-1:0]    fifo_count;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_entry;
    logic [31:0]        fill_sum;
    logic [31:0]        issue_sum;
    logic               req_valid;
    logic               req_fire;
    logic               resp_keep;
    logic               resp_drop;
    logic               push;
    logic               pop;

    assign redirect_target = redirect_pc & ~XLEN'(PC_ALIGN_MASK);

    // Credit check uses registered state only. The first term reserves a FIFO
    // slot for every live request; the second bounds traffic on the memory bus
    // including responses that will be thrown away. fetch_en holds requests
    // off while reset is asserted.
    assign fill_sum  = 32'(inflight) + 32'(fifo_count);
    assign issue_sum = 32'(inflight) + 32'(drop);
    assign req_valid = fetch_en && (fill_sum < FIFO_DEPTH) && (issue_sum < MAX_OUTSTANDING);
    assign req_fire  = req_valid && bus.imem_req_ready;

    // Responses return in order, so the oldest outstanding ones are the stale
    // ones: while drop is non-zero each arrival is discarded.
    assign resp_drop = bus.imem_resp_valid && (drop != '0);
    assign resp_keep = bus.imem_resp_valid && (drop == '0);
    assign push      = resp_keep && !redirect_valid;
    assign pop       = !fifo_empty && bus.out_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = !fifo_empty;
    assign bus.instruction    = fifo_empty ? RESET_INSTR : head_entry[ENTRY_W-1:XLEN];
    assign bus.out_pc_value   = fifo_empty ? '0 : head_entry[XLEN-1:0];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({bus.imem_resp_data, tag_pc}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // Outstanding-request bookkeeping. On a redirect everything issued so far,
    // including a request firing this cycle, becomes a drop; a response arriving
    // in the same cycle retires one of them whichever counter it belonged to.
    always_comb begin
        inflight_next = inflight;
        drop_next     = drop;
        if (redirect_valid) begin
            inflight_next = '0;
            drop_next     = drop + inflight + CNT_W'(req_fire) - CNT_W'(bus.imem_resp_valid);
        end else begin
            inflight_next = inflight + CNT_W'(req_fire) - CNT_W'(resp_keep);
            drop_next     = drop - CNT_W'(resp_drop);
        end
    end

    // Fetch PC advances per accepted request, tag PC per buffered entry; both
    // restart together at the aligned target on a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_en <= 1'b0;
            fetch_pc <= RESET_PC;
            tag_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            fetch_en <= 1'b1;
            inflight <= inflight_next;
            drop     <= drop_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
                tag_pc   <= redirect_target;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                end
                if (push) begin
                    tag_pc <= tag_pc + XLEN'(PC_STEP);
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch: an in-order instruction memory with
// one-cycle latency and a hold switch, a decode-side consumer, and a recorder
// of every delivered {instruction, PC} pair and every accepted request address.
// ----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_hold;

    int checks = 0;
    int errors = 0;

    logic [31:0] got_pc   [$];
    logic [31:0] got_ins  [$];
    logic [31:0] pend     [$];
    logic [31:0] fire_log [$];
    int          fire_cnt;
    int          resp_cnt;
    int          max_out = 0;

    instruction_fetch_if #(.XLEN(32)) bus ();

    instruction_fetch #(
        .XLEN            (32),
        .RESET_PC        (32'h0),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] got_pc_at(input int idx);
        if (idx < got_pc.size()) return got_pc[idx];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] got_ins_at(input int idx);
        if (idx < got_ins.size()) return got_ins[idx];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] fire_at(input int idx);
        if (idx < fire_log.size()) return fire_log[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // Memory model: answers each accepted request one cycle later, in order;
    // while held, requests queue up and are released one per cycle afterwards.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.imem_resp_valid <= 1'b0;
            bus.imem_resp_data  <= '0;
            fire_cnt            <= 0;
            resp_cnt            <= 0;
            pend.delete();
        end else begin
            bus.imem_resp_valid <= 1'b0;
            if (bus.imem_resp_valid) begin
                resp_cnt <= resp_cnt + 1;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                fire_cnt <= fire_cnt + 1;
                fire_log.push_back(bus.imem_req_addr);
            end
            if (!mem_hold && pend.size() > 0) begin
                bus.imem_resp_valid <= 1'b1;
                bus.imem_resp_data  <= mem_word(pend[0]);
                pend.pop_front();
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    pend.push_back(bus.imem_req_addr);
                end
            end else if (!mem_hold && bus.imem_req_valid && bus.imem_req_ready) begin
                bus.imem_resp_valid <= 1'b1;
                bus.imem_resp_data  <= mem_word(bus.imem_req_addr);
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                pend.push_back(bus.imem_req_addr);
            end
        end
    end

    // Record every pair decode actually takes.
    always @(posedge clk) begin
        if (rst && bus.out_valid && bus.out_ready) begin
            got_pc.push_back(bus.out_pc_value);
            got_ins.push_back(bus.instruction);
        end
    end

    // Track the largest number of requests seen on the bus without a response.
    always @(negedge clk) begin
        if ((fire_cnt - resp_cnt) > max_out) begin
            max_out <= fire_cnt - resp_cnt;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ordy,
                                 input logic hold, input int cycles);
        redirect_valid = rv;
        redirect_pc    = rpc;
        bus.out_ready  = ordy;
        mem_hold       = hold;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyReset(input logic ordy, input logic hold);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.out_ready  = ordy;
        mem_hold       = hold;
        repeat (3) @(negedge clk);
        got_pc.delete();
        got_ins.delete();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wait_cnt;
        int n_before;
        int mark;
        int fmark;
        logic found;

        rst                = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        mem_hold           = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_instruction", bus.instruction, 0);
        checkOutput("rst_out_pc", bus.out_pc_value, 0);
        checkOutput("rst_req_valid", bus.imem_req_valid, 0);

        $display("[TB] streaming from RESET_PC");
        rst = 1'b1;
        wait_cnt = 0;
        while (!bus.imem_req_valid && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        checkOutput("first_req_seen", bus.imem_req_valid, 1);
        checkOutput("first_req_addr", bus.imem_req_addr, 32'h0);
        repeat (12) @(negedge clk);
        checkOutput("stream_pc0", got_pc_at(0), 32'h0);
        checkOutput("stream_ins0", got_ins_at(0), mem_word(32'h0));
        checkOutput("stream_pc1", got_pc_at(1), 32'h4);
        checkOutput("stream_ins1", got_ins_at(1), mem_word(32'h4));
        checkOutput("stream_pc2", got_pc_at(2), 32'h8);
        checkOutput("stream_ins2", got_ins_at(2), mem_word(32'h8));

        $display("[TB] decode back-pressure");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 10);
        n_before = got_pc.size();
        checkOutput("stall_out_valid", bus.out_valid, 1);
        checkOutput("stall_req_valid", bus.imem_req_valid, 0);
        checkOutput("stall_head_pc", bus.out_pc_value, 32'(n_before * 4));
        checkOutput("stall_head_ins", bus.instruction, mem_word(32'(n_before * 4)));
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 10);
        checkOutput("drain_progress", got_pc.size() >= n_before + 2, 1);
        for (int i = 0; i < got_pc.size(); i++) begin
            checkOutput($sformatf("seq_pc_%0d", i), got_pc[i], 32'(i * 4));
            checkOutput($sformatf("seq_ins_%0d", i), got_ins[i], mem_word(32'(i * 4)));
        end

        $display("[TB] redirect with two requests in flight");
        applyReset(1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 8);
        checkOutput("fill_none_taken", got_pc.size(), 0);
        checkOutput("fill_out_valid", bus.out_valid, 1);
        checkOutput("fill_req_valid", bus.imem_req_valid, 0);
        checkOutput("fill_head_pc", bus.out_pc_value, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 8);
        checkOutput("held_taken", got_pc.size(), 2);
        checkOutput("held_pending", pend.size(), 2);
        checkOutput("held_req_valid", bus.imem_req_valid, 0);
        checkOutput("held_out_valid", bus.out_valid, 0);
        checkOutput("held_addr8", fire_at(fire_log.size() - 2), 32'h8);
        checkOutput("held_addrC", fire_at(fire_log.size() - 1), 32'hC);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 15);
        checkOutput("redir_pc0", got_pc_at(2), 32'h100);
        checkOutput("redir_ins0", got_ins_at(2), mem_word(32'h100));
        checkOutput("redir_pc1", got_pc_at(3), 32'h104);
        checkOutput("redir_drop_zero", dut.drop, 0);

        $display("[TB] redirect colliding with request and response");
        applyReset(1'b1, 1'b0);
        found = 1'b0;
        wait_cnt = 0;
        while (!found && wait_cnt < 20) begin
            if (bus.imem_req_valid && bus.imem_req_ready && bus.imem_resp_valid) begin
                found = 1'b1;
            end else begin
                @(negedge clk);
                wait_cnt++;
            end
        end
        checkOutput("collide_found", found, 1);
        applyStimulus(1'b1, 32'h203, 1'b1, 1'b0, 1);
        mark = got_pc.size();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 12);
        checkOutput("collide_pc0", got_pc_at(mark), 32'h200);
        checkOutput("collide_ins0", got_ins_at(mark), mem_word(32'h200));
        checkOutput("collide_pc1", got_pc_at(mark + 1), 32'h204);
        checkOutput("collide_drop_zero", dut.drop, 0);

        $display("[TB] reset mid-stream with a full buffer");
        applyReset(1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 6);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 8);
        checkOutput("pre_rst_out_valid", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", bus.out_valid, 0);
        checkOutput("mid_rst_instruction", bus.instruction, 0);
        checkOutput("mid_rst_out_pc", bus.out_pc_value, 0);
        checkOutput("mid_rst_req_valid", bus.imem_req_valid, 0);
        repeat (2) @(negedge clk);
        got_pc.delete();
        got_ins.delete();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 10);
        checkOutput("after_rst_pc0", got_pc_at(0), 32'h0);
        checkOutput("after_rst_ins0", got_ins_at(0), mem_word(32'h0));

        $display("[TB] fetch PC wrap-around");
        applyReset(1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 6);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1);
        mark  = got_pc.size();
        fmark = fire_log.size();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 12);
        checkOutput("wrap_req0", fire_at(fmark), 32'hFFFF_FFFC);
        checkOutput("wrap_req1", fire_at(fmark + 1), 32'h0);
        checkOutput("wrap_pc0", got_pc_at(mark), 32'hFFFF_FFFC);
        checkOutput("wrap_ins0", got_ins_at(mark), mem_word(32'hFFFF_FFFC));
        checkOutput("wrap_pc1", got_pc_at(mark + 1), 32'h0);

        checkOutput("max_outstanding_ok", max_out <= 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
